// File: rtl/ifetch_queue_if.sv
// ifetch_queue buses: imem read port and ID-side queue head.
interface ifetch_queue_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          id_valid;
    logic [31:0]   inst_id;
    logic [AW-1:0] pc_4_id;
    logic          id_stall;

    modport master (
        output imem_req, imem_addr,
        output id_valid, inst_id, pc_4_id,
        input  imem_ack, imem_rdata,
        input  id_stall
    );

    modport slave (
        input  imem_req, imem_addr,
        input  id_valid, inst_id, pc_4_id,
        output imem_ack, imem_rdata,
        output id_stall
    );
endinterface

// File: rtl/ifetch_queue.sv
// Fetch stage: one-outstanding imem reader feeding a small {inst, pc+4} FIFO.
// Optional IFETCH_BYPASS_EN forwards an ack straight to ID when the FIFO is empty.
module ifetch_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] pc_4_if,
    output logic          pc_adv,
    input  logic          redirect,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, rd_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   inst_q [DEPTH];
    logic [AW-1:0] pc4_q  [DEPTH];
    logic          head_v, accept, byp;
    logic          pop, fifo_pop, push;

    assign pc_4_if = pc + AW'(4);
    assign head_v  = cnt_q != '0;
    assign accept  = (state_q == REQ) && bus.imem_ack && !redirect;

`ifdef IFETCH_BYPASS_EN
    assign byp = accept && !head_v;
`else
    assign byp = 1'b0;
`endif

    assign bus.id_valid  = head_v | byp;
    assign bus.inst_id   = byp ? bus.imem_rdata : inst_q[rd_q];
    assign bus.pc_4_id   = byp ? pc_4_if : pc4_q[rd_q];
    assign bus.imem_req  = state_q != IDLE;
    assign bus.imem_addr = addr_q;

    assign pop      = bus.id_valid && !bus.id_stall;
    assign fifo_pop = pop && head_v;
    // A bypassed word consumed by ID this cycle never enters the FIFO.
    assign push     = accept && !(byp && !bus.id_stall);
    assign pc_adv   = accept;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q + CW'(push) - CW'(fifo_pop);
        if (redirect) cnt_d = '0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && cnt_d < FULL) begin
                    state_d = REQ;
                    addr_d  = pc;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (redirect || cnt_d >= FULL) state_d = IDLE;
                    else addr_d = pc_4_if;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc4_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (redirect) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    inst_q[wr_q] <= bus.imem_rdata;
                    pc4_q[wr_q]  <= pc_4_if;
                    wr_q         <= wr_q + PW'(1);
                end
                if (fifo_pop) rd_q <= rd_q + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a PC register and latency-programmable imem.
module tb_ifetch_queue;
    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic        stale;
    logic        pc_adv;
    logic [31:0] pc, pc_4_if, tgt, pc_rst;
    int          lat, wcnt;
    int          n_cmp, n_bad;

    ifetch_queue_if #(.AW(32)) bus ();

    ifetch_queue #(.DEPTH(2), .AW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc       (pc),
        .pc_4_if  (pc_4_if),
        .pc_adv   (pc_adv),
        .redirect (redirect),
        .bus      (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= pc_rst;
        else if (redirect) pc <= tgt;
        else if (pc_adv) pc <= pc_4_if;
    end

    assign bus.imem_ack   = stale | (bus.imem_req && wcnt == lat);
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (bus.imem_ack) wcnt <= 0;
        else if (bus.imem_req) wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] v, input int l,
                           input logic st);
        @(negedge clk);
        pc_rst       = v;
        lat          = l;
        bus.id_stall = st;
        redirect     = 1'b0;
        stale        = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int k;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        redirect = 1'b0;
        tgt = '0;
        stale = 1'b0;
        lat = 0;
        bus.id_stall = 1'b0;
        pc_rst = 32'h0040_0000;

        // reset state and zero-latency streaming
        step();
        chk("rst_req",   bus.imem_req, 0);
        chk("rst_valid", bus.id_valid, 0);
        chk("rst_adv",   pc_adv, 0);
        chk("rst_inst",  bus.inst_id, 0);
        chk("rst_pc4",   bus.pc_4_id, 0);
        chk("rst_addr",  bus.imem_addr, 0);
        chk("rst_pc4if", pc_4_if, 32'h0040_0004);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("s1_req",   bus.imem_req, 1);
        chk("s1_addr",  bus.imem_addr, 32'h0040_0000);
        chk("s1_adv",   pc_adv, 1);
        chk("s1_valid", bus.id_valid, 0);
        step();
        chk("s2_addr",  bus.imem_addr, 32'h0040_0004);
        chk("s2_adv",   pc_adv, 1);
        chk("s2_valid", bus.id_valid, 1);
        chk("s2_pc4",   bus.pc_4_id, 32'h0040_0004);
        chk("s2_inst",  bus.inst_id, mem_word(32'h0040_0000));
        step();
        chk("s3_addr",  bus.imem_addr, 32'h0040_0008);
        chk("s3_adv",   pc_adv, 1);
        chk("s3_pc4",   bus.pc_4_id, 32'h0040_0008);

        // stall fills FIFO, release resumes
        restart(32'h0000_1000, 0, 1'b1);
        step();
        chk("st1_addr", bus.imem_addr, 32'h0000_1000);
        chk("st1_adv",  pc_adv, 1);
        step();
        chk("st2_addr", bus.imem_addr, 32'h0000_1004);
        chk("st2_adv",  pc_adv, 1);
        chk("st2_pc4",  bus.pc_4_id, 32'h0000_1004);
        step();
        chk("st3_req",  bus.imem_req, 0);
        chk("st3_adv",  pc_adv, 0);
        chk("st3_valid", bus.id_valid, 1);
        step();
        chk("st4_req",  bus.imem_req, 0);
        bus.id_stall = 1'b0;
        #1;
        chk("st4_pc4",  bus.pc_4_id, 32'h0000_1004);
        chk("st4_inst", bus.inst_id, mem_word(32'h0000_1000));
        chk("st4_adv",  pc_adv, 0);
        step();
        chk("st5_req",  bus.imem_req, 1);
        chk("st5_addr", bus.imem_addr, 32'h0000_1008);
        chk("st5_pc4",  bus.pc_4_id, 32'h0000_1008);
        chk("st5_inst", bus.inst_id, mem_word(32'h0000_1004));

        // redirect during a slow fetch
        restart(32'h0000_2000, 3, 1'b0);
        step();
        chk("dc1_req",  bus.imem_req, 1);
        chk("dc1_addr", bus.imem_addr, 32'h0000_2000);
        redirect = 1'b1;
        tgt = 32'h0000_0100;
        #1;
        chk("dc1_adv",  pc_adv, 0);
        step();
        redirect = 1'b0;
        chk("dc2_req",  bus.imem_req, 1);
        chk("dc2_addr", bus.imem_addr, 32'h0000_2000);
        chk("dc2_valid", bus.id_valid, 0);
        step();
        chk("dc3_req",  bus.imem_req, 1);
        step();
        chk("dc4_ack",  bus.imem_ack, 1);
        chk("dc4_adv",  pc_adv, 0);
        chk("dc4_addr", bus.imem_addr, 32'h0000_2000);
        step();
        chk("dc5_req",  bus.imem_req, 0);
        chk("dc5_valid", bus.id_valid, 0);
        step();
        chk("dc6_req",  bus.imem_req, 1);
        chk("dc6_addr", bus.imem_addr, 32'h0000_0100);
        chk("dc6_valid", bus.id_valid, 0);

        // redirect and ack together with one entry queued
        restart(32'h0000_3000, 0, 1'b1);
        step();
        chk("ra1_adv",  pc_adv, 1);
        step();
        chk("ra2_valid", bus.id_valid, 1);
        chk("ra2_pc4",  bus.pc_4_id, 32'h0000_3004);
        redirect = 1'b1;
        tgt = 32'h0000_0500;
        #1;
        chk("ra2_adv",  pc_adv, 0);
        step();
        redirect = 1'b0;
        bus.id_stall = 1'b0;
        chk("ra3_valid", bus.id_valid, 0);
        chk("ra3_req",  bus.imem_req, 0);
        chk("ra3_adv",  pc_adv, 0);
        step();
        chk("ra4_req",  bus.imem_req, 1);
        chk("ra4_addr", bus.imem_addr, 32'h0000_0500);

        // PC wrap
        restart(32'hFFFF_FFFC, 0, 1'b0);
        step();
        chk("wr1_pc4if", pc_4_if, 32'h0000_0000);
        chk("wr1_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wr1_adv",  pc_adv, 1);
        step();
        chk("wr2_valid", bus.id_valid, 1);
        chk("wr2_pc4",  bus.pc_4_id, 32'h0000_0000);
        chk("wr2_inst", bus.inst_id, mem_word(32'hFFFF_FFFC));
        chk("wr2_addr", bus.imem_addr, 32'h0000_0000);

        // async reset mid-request, stale ack afterwards
        restart(32'h0000_4000, 0, 1'b1);
        step();
        chk("ar1_adv",  pc_adv, 1);
        step();
        chk("ar2_valid", bus.id_valid, 1);
        lat = 3;
        #1;
        chk("ar2_req",  bus.imem_req, 1);
        chk("ar2_adv",  pc_adv, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   bus.imem_req, 0);
        chk("ar_valid", bus.id_valid, 0);
        chk("ar_inst",  bus.inst_id, 0);
        chk("ar_pc4",   bus.pc_4_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b1;
        bus.id_stall = 1'b0;
        #1;
        chk("ar3_req",  bus.imem_req, 0);
        chk("ar3_adv",  pc_adv, 0);
        step();
        stale = 1'b0;
        #1;
        chk("ar4_req",  bus.imem_req, 1);
        chk("ar4_addr", bus.imem_addr, 32'h0000_4000);
        chk("ar4_valid", bus.id_valid, 0);
        chk("ar4_adv",  pc_adv, 0);
        k = 0;
        while (!bus.id_valid && k < 10) begin
            step();
            k++;
        end
        chk("ar_wait",  bus.id_valid, 1);
        chk("ar_pc4w",  bus.pc_4_id, 32'h0000_4004);
        chk("ar_instw", bus.inst_id, mem_word(32'h0000_4000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage between the PC register and the ID stage.
- Takes the current PC and issues one instruction-memory read at a time using a req/ack handshake.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO that feeds ID.
- Produces pc_4_if and the sequential-advance strobe for the PC register; a taken branch/jump redirect flushes the FIFO and discards any in-flight fetch.

Parameters:
- DEPTH, 2, fetch FIFO entries; power of two, ≥2.
- AW, 32, PC/address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  AW  current PC from the PC register.
- pc_4_if  out  AW  pc+4, combinational; sequential-next input of the PC register.
- pc_adv  out  1  combinational; PC register must load pc_4_if this edge.
- redirect  in  1  taken branch/jump/jr this cycle; PC register loads the target this edge.
- imem_req  out  1  read request.
- imem_addr  out  AW  read address, registered.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  FIFO head valid.
- inst_id  out  32  head instruction.
- pc_4_id  out  AW  head PC+4 (ID uses [31:28] for j-target, full value for beq).
- id_stall  in  1  ID cannot accept; pop is suppressed.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO count=0, pointers=0, imem_addr=0.
  - Outputs during reset: imem_req=0, id_valid=0, pc_adv=0, inst_id and pc_4_id = 0.
- pc_4_if = pc + 4, modulo 2^AW (wrap at all-ones is silent).
- imem_req = 1 in REQ and DISCARD. imem_req and imem_addr stay stable until imem_ack. At most one outstanding request.
- pop = id_valid & ~id_stall. Same-cycle push and pop are both legal.
- cnt_next = count after this edge, including push and pop.
- FSM states: IDLE, REQ, DISCARD.
- IDLE:
  - redirect → IDLE, FIFO flushed.
  - else if count<DEPTH (with pop counted) → REQ, imem_addr<=pc.
  - else → IDLE.
- REQ, with ack & ~redirect:
  - Push {imem_rdata, pc_4_if}; pc_adv=1.
  - If cnt_next<DEPTH → stay REQ, imem_addr<=pc_4_if (back-to-back fetch, 1 fetch/cycle at zero memory latency).
  - Otherwise → IDLE.
- REQ, with ack & redirect:
  - Data dropped, pc_adv=0, FIFO flushed → IDLE.
- REQ, with ~ack & redirect:
  - FIFO flushed → DISCARD; request held.
- REQ, with ~ack & ~redirect: stay REQ.
- DISCARD:
  - Request held with the old address.
  - On ack: data dropped, pc_adv=0 → IDLE.
  - A further redirect re-flushes the FIFO and stays in DISCARD.
- Priority: redirect > push/pop. A flush zeroes count and pointers; any same-cycle pop is ignored.
- pc_adv is never asserted except on an accepted push, and never in the same cycle as redirect.
- FIFO full: no new request issued; an outstanding request can never overflow, because issue requires a free slot.
- FIFO empty: id_valid=0; inst_id/pc_4_id hold their last value (don't-care).
- Latency:
  - Ack → id_valid: 1 cycle.
  - Redirect → first new request: 1 cycle (IDLE) after the ack/flush edge.
- Reset mid-fetch: the request is abandoned. The memory must tolerate imem_req dropping; any stale ack arriving while in IDLE is ignored.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state=REQ, imem_ack=1 and redirect=0, then:
    - id_valid=1 combinationally.
    - inst_id=imem_rdata.
    - pc_4_id=pc_4_if.
  - If id_stall=0 the word goes straight to ID and is not pushed; pc_adv is still 1. Ack→ID latency is 0.
  - If id_stall=1 it is pushed normally.
- Undefined: all data passes through the FIFO; latency is 1 cycle.

Test Plan:
- Reset, pc=0x00400000, memory acks every request in its first cycle, id_stall=0:
  - imem_addr sequence 0x00400000, 0x00400004, 0x00400008, one per cycle.
  - pc_adv=1 each cycle.
  - pc_4_id sequence 0x00400004, 0x00400008 on consecutive cycles.
- id_stall=1 held, DEPTH=2:
  - Exactly two pushes, then imem_req=0 and state IDLE, count=2.
  - Release stall: pops in order, fetch resumes the cycle after a slot frees.
- Memory latency 3 cycles; redirect asserted the cycle after the request issues to 0x100:
  - Request held until ack, ack data dropped, pc_adv=0.
  - Next request goes to the new pc; FIFO empty throughout.
- redirect and imem_ack in the same cycle with 1 FIFO entry present:
  - count→0, no push, pc_adv=0, id_valid=0 next cycle.
- pc=0xFFFFFFFC:
  - pc_4_if=0x00000000, pushed pc_4_id=0x00000000.
- rst_n pulsed low mid-request:
  - imem_req=0 and id_valid=0 immediately (asynchronously).
  - Stale ack after release is ignored; fetch restarts from pc.
